div_issue_ctrl: RTL and testbench

//  EX-stage requester for the multi-cycle divider. Accepts DIV/DIVU from EX, latches operands,

---
 rtl/div_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage requester for the multi-cycle divider.
// Accepts DIV/DIVU from EX and latches the operands. It holds div_start high until the
// divider pulses div_done, and stalls the pipeline meanwhile. It then offers {HI,LO} to the
// HI/LO writeback on a valid/ready handshake.
// A zero divisor bypasses the divider with HI=dividend, LO=all-ones.
// A watchdog aborts an operation whose divider never answers and sets the sticky div_err.
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   req_valid/_signed   divide request from EX (signed=1 -> DIV), with operands req_opa/req_opb
//   flush               cancels any in-flight divide, highest priority
//   req_ready           controller idle and able to accept
//   stall_req           hold EX and earlier stages
//   div_start, div_unsigned, div_op1, div_op2   divider request side
//   div_result, div_done                        divider response ({remainder, quotient})
//   res_valid, res_ready, res_hi, res_lo        HI/LO writeback handshake
//   div_err             sticky watchdog error, cleared only by reset
module div_issue_ctrl #(
    parameter int unsigned DIV_CYCLES = 36,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_opa,
    input  logic [31:0] req_opb,
    input  logic        flush,
    output logic        req_ready,
    output logic        stall_req,
    output logic        div_start,
    output logic        div_unsigned,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [63:0] div_result,
    input  logic        div_done,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_err
);

    // Watchdog counter is sized for whichever of the divider latency or the timeout is larger.
    localparam int unsigned WdMax = (TIMEOUT > DIV_CYCLES) ? TIMEOUT : DIV_CYCLES;
    localparam int unsigned CntW  = $clog2(WdMax + 1);
    localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t          state;
    logic [CntW-1:0] wd_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            wd_cnt       <= '0;
            req_ready    <= 1'b1;
            div_start    <= 1'b0;
            res_valid    <= 1'b0;
            div_unsigned <= 1'b0;
            div_op1      <= '0;
            div_op2      <= '0;
            res_hi       <= '0;
            res_lo       <= '0;
            div_err      <= 1'b0;
        end else if (flush) begin
            // Dropping div_start is enough to make the divider abandon its work.
            state     <= StIdle;
            wd_cnt    <= '0;
            req_ready <= 1'b1;
            div_start <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        div_op1      <= req_opa;
                        div_op2      <= req_opb;
                        div_unsigned <= ~req_signed;
                        wd_cnt       <= '0;
                        req_ready    <= 1'b0;
                        if (req_opb != 32'd0) begin
                            state     <= StBusy;
                            div_start <= 1'b1;
                        end else begin
                            // Divide by zero: answer directly, divider never started.
                            state     <= StDone;
                            res_valid <= 1'b1;
                            res_hi    <= req_opa;
                            res_lo    <= 32'hFFFF_FFFF;
                        end
                    end
                end
                StBusy: begin
                    if (div_done) begin
                        // div_start must fall now or the divider would re-arm.
                        state     <= StDone;
                        div_start <= 1'b0;
                        res_valid <= 1'b1;
                        res_hi    <= div_result[63:32];
                        res_lo    <= div_result[31:0];
                    end else if (wd_cnt == WdLast) begin
                        state     <= StIdle;
                        div_start <= 1'b0;
                        req_ready <= 1'b1;
                        div_err   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        state     <= StIdle;
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    div_start <= 1'b0;
                    res_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stall depends on same-cycle inputs, so it is decoded combinationally.
    always_comb begin
        stall_req = 1'b0;
        unique case (state)
            StIdle:  stall_req = req_valid & ~flush;
            StBusy:  stall_req = 1'b1;
            StDone:  stall_req = ~res_ready;
            default: stall_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: randomized and directed bench for div_issue_ctrl. Includes a divider
// model that answers DivCycles+1 cycles after start, or never when hang is set.
module tb_div_issue_ctrl;

    localparam int unsigned DivCycles = 36;
    localparam int unsigned Timeout   = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] req_opa = '0;
    logic [31:0] req_opb = '0;
    logic        flush = 1'b0;
    logic        req_ready, stall_req, div_start, div_unsigned;
    logic [31:0] div_op1, div_op2;
    logic [63:0] div_result;
    logic        div_done;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_hi, res_lo;
    logic        div_err;
    logic        hang = 1'b0;
    int unsigned dcnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    div_issue_ctrl #(.DIV_CYCLES(DivCycles), .TIMEOUT(Timeout)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_signed(req_signed),
        .req_opa(req_opa), .req_opb(req_opb), .flush(flush), .req_ready(req_ready),
        .stall_req(stall_req), .div_start(div_start), .div_unsigned(div_unsigned),
        .div_op1(div_op1), .div_op2(div_op2), .div_result(div_result), .div_done(div_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_hi(res_hi), .res_lo(res_lo),
        .div_err(div_err)
    );

    // MIPS divide semantics: {remainder, quotient}, truncation toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    // Divider model: counts cycles of div_start, pulses done on the (DivCycles+1)-th.
    always @(posedge clock or negedge reset) begin
        if (!reset)         dcnt <= 0;
        else if (div_start) dcnt <= dcnt + 1;
        else                dcnt <= 0;
    end
    assign div_done   = div_start && !hang && (dcnt == DivCycles);
    assign div_result = ref_div(div_op1, div_op2, ~div_unsigned);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete operation; hold = cycles res_ready stays low once in DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int unsigned hold);
        logic [63:0] exp;
        int unsigned lat, starts;
        exp = ref_div(a, b, sgn);
        @(negedge clock);
        req_valid = 1'b1; req_opa = a; req_opb = b; req_signed = sgn;
        res_ready = (hold == 0);
        #1;
        check("req_ready_idle", 64'(req_ready), 64'(1));
        check("stall_on_req", 64'(stall_req), 64'(1));
        @(negedge clock);
        req_valid = 1'b0; req_opa = $urandom; req_opb = $urandom; req_signed = $urandom_range(0, 1);
        lat = 0; starts = 0;
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge clock);
            if (n == 1 && b != 32'd0) begin
                check("op1_latched", 64'(div_op1), 64'(a));
                check("op2_latched", 64'(div_op2), 64'(b));
                check("unsigned_flag", 64'(div_unsigned), 64'(!sgn));
                check("stall_busy", 64'(stall_req), 64'(1));
            end
            if (div_start) starts++;
            if (res_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", 64'(lat), (b != 32'd0) ? 64'(DivCycles + 2) : 64'(1));
        check("start_cycles", 64'(starts), (b != 32'd0) ? 64'(DivCycles + 1) : 64'(0));
        check("hi_lo", {res_hi, res_lo}, exp);
        for (int k = 0; k < int'(hold); k++) begin
            if (k > 0) @(negedge clock);
            check("held_valid", 64'(res_valid), 64'(1));
            check("held_hi_lo", {res_hi, res_lo}, exp);
            check("held_stall", 64'(stall_req), 64'(1));
        end
        res_ready = 1'b1;
        #1;
        check("stall_accept", 64'(stall_req), 64'(0));
        @(negedge clock);
        check("idle_after", 64'({req_ready, res_valid, div_start}), 64'(3'b100));
    endtask

    initial begin
        int unsigned starts, n_end;
        logic        seen;
        logic [31:0] a, b;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_outs", 64'({stall_req, div_start, res_valid, div_err, div_unsigned}), 64'(0));
        check("rst_data", {div_op1, div_op2, res_hi, res_lo} == '0 ? 64'(1) : 64'(0), 64'(1));
        reset = 1'b1;

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(-32'sd7, 32'd2, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'd5, 32'd0, 1'b1, 0);
        run_op(32'd1234, 32'd10, 1'b0, 4);

        // Flush at T+10 of BUSY
        @(negedge clock);
        req_valid = 1'b1; req_opa = 32'd1000; req_opb = 32'd3; req_signed = 1'b0; res_ready = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_busy", 64'({div_start, res_valid, req_ready}), 64'(3'b001));
        seen = 1'b0;
        repeat (45) begin
            @(negedge clock);
            if (res_valid || div_start) seen = 1'b1;
        end
        check("flush_no_result", 64'(seen), 64'(0));
        run_op(32'd9, 32'd3, 1'b0, 0);

        // Flush in the same cycle as a request
        @(negedge clock);
        req_valid = 1'b1; flush = 1'b1; req_opa = 32'd50; req_opb = 32'd5;
        #1;
        check("flush_req_stall", 64'(stall_req), 64'(0));
        @(negedge clock);
        req_valid = 1'b0; flush = 1'b0;
        check("flush_req_ignored", 64'({div_start, res_valid, req_ready}), 64'(3'b001));

        // Flush in DONE
        @(negedge clock);
        req_valid = 1'b1; req_opa = 32'd77; req_opb = 32'd0; res_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        check("done_valid", 64'(res_valid), 64'(1));
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_done", 64'({res_valid, req_ready}), 64'(2'b01));

        // Flush coinciding with div_done
        @(negedge clock);
        req_valid = 1'b1; req_opa = 32'd81; req_opb = 32'd9; res_ready = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (DivCycles) @(negedge clock);
        check("done_pulse_t37", 64'(div_done), 64'(1));
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_on_done", 64'({res_valid, div_start, req_ready}), 64'(3'b001));

        // Random operations
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Watchdog: divider never answers
        hang = 1'b1;
        @(negedge clock);
        req_valid = 1'b1; req_opa = 32'd10; req_opb = 32'd2;
        @(negedge clock);
        req_valid = 1'b0;
        check("err_before", 64'(div_err), 64'(0));
        starts = 0; n_end = 0; seen = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge clock);
            if (div_start) starts++;
            if (res_valid) seen = 1'b1;
            if (req_ready) begin
                n_end = n;
                break;
            end
        end
        check("wd_busy_cycles", 64'(starts), 64'(Timeout));
        check("wd_idle_at", 64'(n_end), 64'(Timeout + 1));
        check("wd_no_result", 64'(seen), 64'(0));
        check("wd_err", 64'(div_err), 64'(1));
        hang = 1'b0;
        run_op(32'd20, 32'd6, 1'b0, 0);
        check("err_sticky", 64'(div_err), 64'(1));

        // Reset in the middle of BUSY
        @(negedge clock);
        req_valid = 1'b1; req_opa = 32'd300; req_opb = 32'd7;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({req_ready, stall_req, div_start, res_valid, div_err}),
              64'(5'b10000));
        check("rst_mid_data", {div_op1, res_lo}, 64'(0));
        @(negedge clock);
        reset = 1'b1;
        run_op(32'hFFFF_FFF0, 32'd3, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
